rggen_host_if_axi4lite: RTL and testbench

//  AXI4-Lite slave host interface for generated register blocks; drop-in alternative to the APB host IF.

---
 rtl/rggen_rtl_pkg.sv | 20 ++
 rtl/rggen_host_if_axi4lite.sv | 180 ++++++++++++++++++
 tb/tb_rggen_host_if_axi4lite.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen host interfaces.
// Response status codes and the AXI4-Lite host FSM encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY   = 2'b00,
        RGGEN_EXOKAY = 2'b01,
        RGGEN_SLVERR = 2'b10,
        RGGEN_DECERR = 2'b11
    } rggen_status;

    typedef enum logic [2:0] {
        IDLE,
        CMD_W,
        CMD_R,
        RSP_B,
        RSP_R
    } rggen_axi4lite_state;

endpackage

// File: rtl/rggen_host_if_axi4lite.sv
// AXI4-Lite slave host interface for generated register blocks.
// Serialises AW/W and AR traffic into single register commands.
module rggen_host_if_axi4lite
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int HOST_ADDRESS_WIDTH  = 16,
    parameter int LOCAL_ADDRESS_WIDTH = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_awvalid,
    output logic                           o_awready,
    input  logic [HOST_ADDRESS_WIDTH-1:0]  i_awaddr,
    input  logic [2:0]                     i_awprot,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [HOST_ADDRESS_WIDTH-1:0]  i_araddr,
    input  logic [2:0]                     i_arprot,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [1:0]                     o_rresp,
    output logic                           o_command_valid,
    output logic                           o_write,
    output logic                           o_read,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH/8-1:0]        o_strobe,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    output logic [DATA_WIDTH-1:0]          o_write_mask,
    input  logic                           i_response_ready,
    input  logic [DATA_WIDTH-1:0]          i_read_data,
    input  logic [1:0]                     i_status
);

    localparam int SW = DATA_WIDTH / 8;

    rggen_axi4lite_state state;
    rggen_axi4lite_state state_next;

    logic                           read_first;
    logic                           write_eligible;
    logic                           read_eligible;
    logic                           accept_write;
    logic                           accept_read;
    logic                           in_command;
    logic [LOCAL_ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]          write_data_q;
    logic [SW-1:0]                  strobe_q;
    logic [DATA_WIDTH-1:0]          mask;
    rggen_status                    status_q;
    logic [DATA_WIDTH-1:0]          read_data_q;
    logic                           unused_inputs;

    assign unused_inputs = ^{i_awprot, i_arprot, i_awaddr, i_araddr};

    // When both sides are eligible, serve the one not served last time.
    always_comb begin
        write_eligible = i_awvalid && i_wvalid;
        read_eligible  = i_arvalid;
        accept_read    = (state == IDLE) && read_eligible
                      && (!write_eligible || read_first);
        accept_write   = (state == IDLE) && write_eligible && !accept_read;
        in_command     = (state == CMD_W) || (state == CMD_R);
    end

    for (genvar i = 0; i < SW; i++) begin : g_mask
        assign mask[8*i+:8] = {8{strobe_q[i]}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept_read) begin
                    state_next = CMD_R;
                end else if (accept_write) begin
                    state_next = CMD_W;
                end
            end
            CMD_W: if (i_response_ready) state_next = RSP_B;
            CMD_R: if (i_response_ready) state_next = RSP_R;
            RSP_B: if (i_bready) state_next = IDLE;
            RSP_R: if (i_rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_awready       = 1'b0;
        o_wready        = 1'b0;
        o_arready       = 1'b0;
        o_bvalid        = 1'b0;
        o_bresp         = 2'b00;
        o_rvalid        = 1'b0;
        o_rdata         = '0;
        o_rresp         = 2'b00;
        o_command_valid = 1'b0;
        o_write         = 1'b0;
        o_read          = 1'b0;
        o_address       = '0;
        o_strobe        = '0;
        o_write_data    = '0;
        o_write_mask    = '0;
        unique case (state)
            IDLE: begin
                o_awready = accept_write && !rst;
                o_wready  = accept_write && !rst;
                o_arready = accept_read && !rst;
            end
            CMD_W: begin
                o_command_valid = 1'b1;
                o_write         = 1'b1;
                o_address       = address_q;
                o_strobe        = strobe_q;
                o_write_data    = write_data_q;
                o_write_mask    = mask;
            end
            CMD_R: begin
                o_command_valid = 1'b1;
                o_read          = 1'b1;
                o_address       = address_q;
                o_strobe        = strobe_q;
            end
            RSP_B: begin
                o_bvalid = 1'b1;
                o_bresp  = status_q;
            end
            RSP_R: begin
                o_rvalid = 1'b1;
                o_rdata  = read_data_q;
                o_rresp  = status_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_first   <= 1'b1;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            status_q     <= RGGEN_OKAY;
            read_data_q  <= '0;
        end else begin
            if (accept_read) begin
                read_first   <= 1'b0;
                address_q    <= i_araddr[LOCAL_ADDRESS_WIDTH-1:0];
                write_data_q <= '0;
                strobe_q     <= '1;
            end else if (accept_write) begin
                read_first   <= 1'b1;
                address_q    <= i_awaddr[LOCAL_ADDRESS_WIDTH-1:0];
                write_data_q <= i_wdata;
                strobe_q     <= i_wstrb;
            end
            if (in_command && i_response_ready) begin
                status_q    <= rggen_status'(i_status);
                read_data_q <= (state == CMD_R) ? i_read_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_rggen_host_if_axi4lite.sv
// Self-checking bench for rggen_host_if_axi4lite.
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_rggen_host_if_axi4lite;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, wvalid = 0, arvalid = 0;
    logic        bready = 0, rready = 0, response_ready = 0;
    logic [15:0] awaddr = 0, araddr = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic [31:0] wdata = 0, read_data = 0;
    logic [3:0]  wstrb = 0;
    logic [1:0]  status = 0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic        command_valid, write, read;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, write_data, write_mask;
    logic [6:0]  address;
    logic [3:0]  strobe;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level model
    bit          m_busy, m_rsp, m_is_read, m_read_prio;
    logic [6:0]  m_addr;
    logic [31:0] m_data, m_rdata;
    logic [3:0]  m_strb;
    logic [1:0]  m_status;
    bit          take_r, take_w;

    rggen_host_if_axi4lite dut (
        .clk(clk), .rst(rst),
        .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
        .i_awprot(awprot), .i_wvalid(wvalid), .o_wready(wready),
        .i_wdata(wdata), .i_wstrb(wstrb), .o_bvalid(bvalid),
        .i_bready(bready), .o_bresp(bresp), .i_arvalid(arvalid),
        .o_arready(arready), .i_araddr(araddr), .i_arprot(arprot),
        .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
        .o_rresp(rresp), .o_command_valid(command_valid),
        .o_write(write), .o_read(read), .o_address(address),
        .o_strobe(strobe), .o_write_data(write_data),
        .o_write_mask(write_mask), .i_response_ready(response_ready),
        .i_read_data(read_data), .i_status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = s[i/8];
        return m;
    endfunction

    task automatic reset_model();
        m_busy = 0; m_rsp = 0; m_is_read = 0; m_read_prio = 1;
        m_addr = 0; m_data = 0; m_rdata = 0; m_strb = 0; m_status = 0;
    endtask

    task automatic compare_model();
        bit idle, wr_ok, cmd, bv, rv;
        idle  = !m_busy && !rst;
        wr_ok = awvalid && wvalid;
        take_r = idle && arvalid && (!wr_ok || m_read_prio);
        take_w = idle && wr_ok && !take_r;
        cmd = m_busy && !m_rsp && !rst;
        bv  = m_busy && m_rsp && !m_is_read && !rst;
        rv  = m_busy && m_rsp && m_is_read && !rst;
        chk("awready", awready, take_w);
        chk("wready", wready, take_w);
        chk("arready", arready, take_r);
        chk("command_valid", command_valid, cmd);
        chk("write", write, cmd && !m_is_read);
        chk("read", read, cmd && m_is_read);
        chk("address", address, cmd ? m_addr : 7'd0);
        chk("strobe", strobe, !cmd ? 4'h0 : (m_is_read ? 4'hF : m_strb));
        chk("write_data", write_data,
            (cmd && !m_is_read) ? m_data : 32'd0);
        chk("write_mask", write_mask,
            (cmd && !m_is_read) ? expand(m_strb) : 32'd0);
        chk("bvalid", bvalid, bv);
        chk("bresp", bresp, bv ? m_status : 2'd0);
        chk("rvalid", rvalid, rv);
        chk("rdata", rdata, rv ? m_rdata : 32'd0);
        chk("rresp", rresp, rv ? m_status : 2'd0);
    endtask

    task automatic update_model();
        if (rst) begin
            reset_model();
        end else if (take_r || take_w) begin
            m_busy = 1; m_rsp = 0; m_is_read = take_r;
            m_read_prio = take_w;
            m_addr = take_r ? araddr[6:0] : awaddr[6:0];
            m_data = wdata; m_strb = wstrb;
        end else if (m_busy && !m_rsp && response_ready) begin
            m_rsp = 1; m_status = status; m_rdata = read_data;
        end else if (m_busy && m_rsp
                     && (m_is_read ? rready : bready)) begin
            m_busy = 0; m_rsp = 0;
        end
    endtask

    task automatic cmp_cycle();
        @(negedge clk);
        compare_model();
    endtask

    task automatic adv();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cmp_cycle();
        adv();
    endtask

    task automatic clear_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 0; rready = 0; response_ready = 0;
    endtask

    initial begin
        reset_model();
        repeat (2) tick();
        chk("reset_command_valid", command_valid, 1'b0);
        chk("reset_bvalid", bvalid, 1'b0);
        rst = 0;

        // write: addr 0x0004, data 0xDEADBEEF, strb 0xF
        awvalid = 1; wvalid = 1; awaddr = 16'h0004;
        wdata = 32'hDEADBEEF; wstrb = 4'hF;
        cmp_cycle();
        chk("wr_awready", awready, 1'b1);
        chk("wr_wready", wready, 1'b1);
        adv();
        clear_inputs(); response_ready = 1; status = 2'b00;
        cmp_cycle();
        chk("wr_cmd_valid", command_valid, 1'b1);
        chk("wr_address", address, 7'h04);
        chk("wr_mask", write_mask, 32'hFFFFFFFF);
        chk("wr_data", write_data, 32'hDEADBEEF);
        adv();
        clear_inputs(); bready = 1;
        cmp_cycle();
        chk("wr_bvalid", bvalid, 1'b1);
        chk("wr_bresp", bresp, 2'b00);
        adv();
        clear_inputs();

        // read: addr 0x0008, response one cycle after command
        arvalid = 1; araddr = 16'h0008;
        cmp_cycle();
        chk("rd_arready", arready, 1'b1);
        adv();
        clear_inputs();
        cmp_cycle();
        chk("rd_cmd_read", read, 1'b1);
        chk("rd_strobe", strobe, 4'hF);
        adv();
        response_ready = 1; read_data = 32'h00010001;
        tick();
        clear_inputs(); rready = 1;
        cmp_cycle();
        chk("rd_rvalid", rvalid, 1'b1);
        chk("rd_rdata", rdata, 32'h00010001);
        chk("rd_rresp", rresp, 2'b00);
        adv();
        clear_inputs();

        // AW without W for 5 cycles
        awvalid = 1; awaddr = 16'h0010; wdata = 32'h12345678; wstrb = 4'h3;
        repeat (5) begin
            cmp_cycle();
            chk("aw_only_awready", awready, 1'b0);
            adv();
        end
        wvalid = 1;
        cmp_cycle();
        chk("aw_w_awready", awready, 1'b1);
        chk("aw_w_wready", wready, 1'b1);
        adv();
        clear_inputs(); response_ready = 1;
        tick();
        clear_inputs(); bready = 1;
        tick();
        clear_inputs();

        // both eligible twice: read first, then write
        repeat (2) begin
            awvalid = 1; wvalid = 1; arvalid = 1;
            awaddr = 16'h0020; araddr = 16'h0024;
            cmp_cycle();
            if (m_read_prio) begin
                chk("rr_first_arready", arready, 1'b1);
                chk("rr_first_awready", awready, 1'b0);
            end else begin
                chk("rr_second_awready", awready, 1'b1);
                chk("rr_second_arready", arready, 1'b0);
            end
            adv();
            clear_inputs(); response_ready = 1;
            tick();
            clear_inputs(); bready = 1; rready = 1;
            tick();
            clear_inputs();
        end

        // backpressure on B with SLVERR, AR waiting
        awvalid = 1; wvalid = 1; awaddr = 16'h0030; wstrb = 4'h5;
        tick();
        clear_inputs(); response_ready = 1; status = 2'b10;
        tick();
        clear_inputs(); arvalid = 1; araddr = 16'h0034;
        repeat (4) begin
            cmp_cycle();
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_bresp", bresp, 2'b10);
            chk("bp_arready", arready, 1'b0);
            adv();
        end
        bready = 1;
        tick();
        bready = 0;
        cmp_cycle();
        chk("bp_arready_after", arready, 1'b1);
        adv();
        clear_inputs(); response_ready = 1; read_data = 32'hA5A5_0F0F;
        status = 2'b00;
        tick();
        clear_inputs(); rready = 1;
        tick();
        clear_inputs();

        // reset pulse while in CMD_R
        arvalid = 1; araddr = 16'h0040;
        tick();
        clear_inputs();
        #2 rst = 1;
        #1;
        chk("rst_cmd_valid", command_valid, 1'b0);
        chk("rst_read", read, 1'b0);
        chk("rst_address", address, 7'd0);
        chk("rst_strobe", strobe, 4'd0);
        reset_model();
        tick();
        rst = 0;
        arvalid = 1; araddr = 16'h0048;
        cmp_cycle();
        chk("post_rst_arready", arready, 1'b1);
        adv();
        clear_inputs(); response_ready = 1; read_data = 32'h0000_BEEF;
        tick();
        clear_inputs(); rready = 1;
        cmp_cycle();
        chk("post_rst_rdata", rdata, 32'h0000_BEEF);
        adv();
        clear_inputs();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            awvalid = ($urandom_range(0, 2) != 0);
            wvalid = ($urandom_range(0, 2) != 0);
            arvalid = ($urandom_range(0, 1) != 0);
            awaddr = 16'($urandom);
            araddr = 16'($urandom);
            wdata = $urandom;
            wstrb = 4'($urandom);
            awprot = 3'($urandom);
            arprot = 3'($urandom);
            response_ready = ($urandom_range(0, 1) != 0);
            read_data = $urandom;
            status = 2'($urandom);
            bready = ($urandom_range(0, 2) != 0);
            rready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 0;
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
